maq_bcd_mod: RTL and testbench

//  Parametrised two-digit BCD modulo counter for the digital clock datapath.

---
 rtl/maq_bcd_mod.sv | 136 +++++++++++++
 tb/tb_maq_bcd_mod.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maq_bcd_mod.sv
//==============================================================================
// Module   : maq_bcd_mod
// Purpose  : Two-digit BCD modulo counter for the digital clock datapath.
//            Counts up or down between MIN_VAL and MAX_VAL with wrap-around,
//            emits a combinational terminal-count carry/borrow for cascading,
//            and accepts a synchronous preset.
// Ports    : maqm_clock    - rising-edge clock
//            maqm_reset    - asynchronous active-low reset
//            maqm_enable   - count tick, one step per cycle while high
//            maqm_down     - 0 = count up, 1 = count down
//            maqm_load     - synchronous preset strobe (beats enable)
//            maqm_load_lsd - preset units digit (BCD)
//            maqm_load_msd - preset tens digit (BCD)
//            maqm_lsd      - current units digit
//            maqm_msd      - current tens digit
//            maqm_carry    - terminal-count pulse for the next stage
//            maqm_load_err - registered pulse flagging a rejected preset
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module maq_bcd_mod #(
    parameter int MAX_VAL = 59,
    parameter int MIN_VAL = 0,
    parameter int MSD_W   = 3
) (
    input  logic             maqm_clock,
    input  logic             maqm_reset,
    input  logic             maqm_enable,
    input  logic             maqm_down,
    input  logic             maqm_load,
    input  logic [3:0]       maqm_load_lsd,
    input  logic [MSD_W-1:0] maqm_load_msd,
    output logic [3:0]       maqm_lsd,
    output logic [MSD_W-1:0] maqm_msd,
    output logic             maqm_carry,
    output logic             maqm_load_err
);

    // Bounds split into digits so all comparisons stay in BCD.
    localparam logic [3:0]       C_MAX_LSD = 4'(MAX_VAL % 10);
    localparam logic [MSD_W-1:0] C_MAX_MSD = MSD_W'(MAX_VAL / 10);
    localparam logic [3:0]       C_MIN_LSD = 4'(MIN_VAL % 10);
    localparam logic [MSD_W-1:0] C_MIN_MSD = MSD_W'(MIN_VAL / 10);
    localparam logic [MSD_W-1:0] C_MSD_ONE = MSD_W'(1);

    logic [3:0]       lsd_q, lsd_d;
    logic [MSD_W-1:0] msd_q, msd_d;
    logic             load_err_q, load_err_d;

    logic at_max;
    logic at_min;
    logic load_ge_min;
    logic load_le_max;
    logic load_ok;

    assign at_max = (msd_q == C_MAX_MSD) && (lsd_q == C_MAX_LSD);
    assign at_min = (msd_q == C_MIN_MSD) && (lsd_q == C_MIN_LSD);

    // Lexicographic digit compare (tens first, then units) replaces a
    // binary range check on 10*msd+lsd.
    assign load_le_max = (maqm_load_msd < C_MAX_MSD) ||
                         ((maqm_load_msd == C_MAX_MSD) && (maqm_load_lsd <= C_MAX_LSD));

    // A zero lower bound is trivially met; only the 12-hour style bound
    // needs an actual comparison.
    generate
        if (MIN_VAL == 0) begin : g_min_zero
            assign load_ge_min = 1'b1;
        end else begin : g_min_nonzero
            assign load_ge_min = (maqm_load_msd > C_MIN_MSD) ||
                                 ((maqm_load_msd == C_MIN_MSD) && (maqm_load_lsd >= C_MIN_LSD));
        end
    endgenerate

    assign load_ok = (maqm_load_lsd <= 4'd9) && load_ge_min && load_le_max;

    always_comb begin
        lsd_d      = lsd_q;
        msd_d      = msd_q;
        load_err_d = 1'b0;
        if (maqm_load) begin
            if (load_ok) begin
                lsd_d = maqm_load_lsd;
                msd_d = maqm_load_msd;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (maqm_enable) begin
            if (!maqm_down) begin
                if (at_max) begin
                    lsd_d = C_MIN_LSD;
                    msd_d = C_MIN_MSD;
                end else if (lsd_q == 4'd9) begin
                    lsd_d = 4'd0;
                    msd_d = msd_q + C_MSD_ONE;
                end else begin
                    lsd_d = lsd_q + 4'd1;
                end
            end else begin
                if (at_min) begin
                    lsd_d = C_MAX_LSD;
                    msd_d = C_MAX_MSD;
                end else if (lsd_q == 4'd0) begin
                    lsd_d = 4'd9;
                    msd_d = msd_q - C_MSD_ONE;
                end else begin
                    lsd_d = lsd_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge maqm_clock or negedge maqm_reset) begin
        if (!maqm_reset) begin
            lsd_q      <= C_MIN_LSD;
            msd_q      <= C_MIN_MSD;
            load_err_q <= 1'b0;
        end else begin
            lsd_q      <= lsd_d;
            msd_q      <= msd_d;
            load_err_q <= load_err_d;
        end
    end

    // Carry is asserted in the cycle before the wrap edge; a load on the
    // same edge pre-empts the wrap, so it suppresses the carry too.
    assign maqm_carry    = maqm_enable & ~maqm_load & (maqm_down ? at_min : at_max);
    assign maqm_lsd      = lsd_q;
    assign maqm_msd      = msd_q;
    assign maqm_load_err = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_maq_bcd_mod.sv
//==============================================================================
// Module   : tb_maq_bcd_mod
// Purpose  : Self-checking bench for maq_bcd_mod. Drives a 0-59 instance and
//            a 1-12 instance against an arithmetic reference model of the
//            counter value.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_maq_bcd_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en, dn, ld;
    logic [3:0] llsd;
    logic [2:0] lmsd;
    logic [3:0] lsd;
    logic [2:0] msd;
    logic       carry, lerr;

    logic       en2, dn2, ld2;
    logic [3:0] llsd2;
    logic [1:0] lmsd2;
    logic [3:0] lsd2;
    logic [1:0] msd2;
    logic       carry2, lerr2;

    int n_pass  = 0;
    int n_total = 0;
    int mv, mv2;
    bit mle, mle2;

    maq_bcd_mod #(.MAX_VAL(59), .MIN_VAL(0), .MSD_W(3)) dut (
        .maqm_clock(clk), .maqm_reset(rst_n), .maqm_enable(en), .maqm_down(dn),
        .maqm_load(ld), .maqm_load_lsd(llsd), .maqm_load_msd(lmsd),
        .maqm_lsd(lsd), .maqm_msd(msd), .maqm_carry(carry), .maqm_load_err(lerr)
    );

    maq_bcd_mod #(.MAX_VAL(12), .MIN_VAL(1), .MSD_W(2)) dut12 (
        .maqm_clock(clk), .maqm_reset(rst_n), .maqm_enable(en2), .maqm_down(dn2),
        .maqm_load(ld2), .maqm_load_lsd(llsd2), .maqm_load_msd(lmsd2),
        .maqm_lsd(lsd2), .maqm_msd(msd2), .maqm_carry(carry2), .maqm_load_err(lerr2)
    );

    // ---------------- reference model (plain decimal arithmetic) ----------
    function automatic bit pre_ok(int m, int l, int mn, int mx);
        return (l <= 9) && (10*m + l >= mn) && (10*m + l <= mx);
    endfunction

    function automatic int step_val(int v, bit e, bit d, bit l, int lm, int ll, int mn, int mx);
        if (l)  return pre_ok(lm, ll, mn, mx) ? 10*lm + ll : v;
        if (!e) return v;
        if (!d) return (v == mx) ? mn : v + 1;
        return (v == mn) ? mx : v - 1;
    endfunction

    function automatic bit exp_carry(int v, bit e, bit d, bit l, int mn, int mx);
        return e && !l && (d ? (v == mn) : (v == mx));
    endfunction

    function automatic logic [6:0] dig(int v);
        return {3'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [5:0] dig2(int v);
        return {2'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_advance;
        mle  = ld  && !pre_ok(int'(lmsd),  int'(llsd),  0, 59);
        mle2 = ld2 && !pre_ok(int'(lmsd2), int'(llsd2), 1, 12);
        mv   = step_val(mv,  en,  dn,  ld,  int'(lmsd),  int'(llsd),  0, 59);
        mv2  = step_val(mv2, en2, dn2, ld2, int'(lmsd2), int'(llsd2), 1, 12);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0;
        en = 0; dn = 0; ld = 0; llsd = 0; lmsd = 0;
        en2 = 0; dn2 = 0; ld2 = 0; llsd2 = 0; lmsd2 = 0;
        repeat (2) tick;
        n_total++; if ({msd, lsd} !== 7'h00) $display("FAIL reset_value: got %h expected 00", {msd, lsd}); else n_pass++;
        n_total++; if (lerr !== 1'b0) $display("FAIL reset_load_err: got %b expected 0", lerr); else n_pass++;
        n_total++; if ({msd2, lsd2} !== 6'h01) $display("FAIL reset_value_12h: got %h expected 01", {msd2, lsd2}); else n_pass++;
        n_total++; if (carry !== 1'b0) $display("FAIL reset_carry: got %b expected 0", carry); else n_pass++;
        rst_n = 1'b1;
        mv = 0; mv2 = 1; mle = 0; mle2 = 0;
    endtask

    task automatic test_count_up;
        en = 1; dn = 0;
        for (int i = 0; i < 61; i++) begin
            #1;
            n_total++; if (carry !== exp_carry(mv, en, dn, ld, 0, 59)) $display("FAIL up_carry: at %0d got %b expected %b", mv, carry, exp_carry(mv, en, dn, ld, 0, 59)); else n_pass++;
            model_advance;
            tick;
            n_total++; if ({msd, lsd} !== dig(mv)) $display("FAIL up_value: got %h expected %h", {msd, lsd}, dig(mv)); else n_pass++;
        end
        n_total++; if ({msd, lsd} !== 7'h01) $display("FAIL up_final: got %h expected 01", {msd, lsd}); else n_pass++;
        en = 0;
    endtask

    task automatic test_count_down;
        en = 1; dn = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if (carry !== exp_carry(mv, en, dn, ld, 0, 59)) $display("FAIL down_carry: at %0d got %b expected %b", mv, carry, exp_carry(mv, en, dn, ld, 0, 59)); else n_pass++;
            model_advance;
            tick;
            n_total++; if ({msd, lsd} !== dig(mv)) $display("FAIL down_value: got %h expected %h", {msd, lsd}, dig(mv)); else n_pass++;
        end
        en = 0; ld = 1; lmsd = 5; llsd = 0;
        model_advance;
        tick;
        ld = 0; en = 1; dn = 1;
        #1;
        n_total++; if (carry !== 1'b0) $display("FAIL borrow_carry: got %b expected 0", carry); else n_pass++;
        model_advance;
        tick;
        n_total++; if ({msd, lsd} !== 7'h49) $display("FAIL tens_borrow: got %h expected 49", {msd, lsd}); else n_pass++;
        en = 0; dn = 0;
    endtask

    task automatic test_12h;
        en2 = 1; dn2 = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_total++; if (carry2 !== exp_carry(mv2, en2, dn2, ld2, 1, 12)) $display("FAIL h12_up_carry: at %0d got %b expected %b", mv2, carry2, exp_carry(mv2, en2, dn2, ld2, 1, 12)); else n_pass++;
            model_advance;
            tick;
            n_total++; if ({msd2, lsd2} !== dig2(mv2)) $display("FAIL h12_up_value: got %h expected %h", {msd2, lsd2}, dig2(mv2)); else n_pass++;
        end
        dn2 = 1;
        #1;
        n_total++; if (carry2 !== 1'b1) $display("FAIL h12_borrow: got %b expected 1", carry2); else n_pass++;
        model_advance;
        tick;
        n_total++; if ({msd2, lsd2} !== 6'h12) $display("FAIL h12_down_wrap: got %h expected 12", {msd2, lsd2}); else n_pass++;
        en2 = 0; dn2 = 0;
    endtask

    task automatic test_load;
        ld = 1; lmsd = 4; llsd = 5;
        model_advance;
        tick;
        ld = 0;
        n_total++; if ({msd, lsd} !== 7'h45) $display("FAIL load_valid: got %h expected 45", {msd, lsd}); else n_pass++;
        n_total++; if (lerr !== 1'b0) $display("FAIL load_valid_err: got %b expected 0", lerr); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            ld = 1;
            if (k == 0) begin lmsd = 6; llsd = 1; end
            else        begin lmsd = 4; llsd = 4'hA; end
            model_advance;
            tick;
            ld = 0;
            n_total++; if ({msd, lsd} !== 7'h45) $display("FAIL load_bad_hold: case %0d got %h expected 45", k, {msd, lsd}); else n_pass++;
            n_total++; if (lerr !== 1'b1) $display("FAIL load_bad_err: case %0d got %b expected 1", k, lerr); else n_pass++;
            model_advance;
            tick;
            n_total++; if (lerr !== 1'b0) $display("FAIL load_err_clear: case %0d got %b expected 0", k, lerr); else n_pass++;
        end
    endtask

    task automatic test_load_priority;
        ld = 1; lmsd = 5; llsd = 9;
        model_advance;
        tick;
        en = 1; dn = 0; lmsd = 3; llsd = 0;
        #1;
        n_total++; if (carry !== 1'b0) $display("FAIL prio_carry: got %b expected 0", carry); else n_pass++;
        model_advance;
        tick;
        ld = 0; en = 0;
        n_total++; if ({msd, lsd} !== 7'h30) $display("FAIL prio_value: got %h expected 30", {msd, lsd}); else n_pass++;
    endtask

    task automatic test_async_reset;
        ld = 1; lmsd = 3; llsd = 5;
        model_advance;
        tick;
        ld = 0; en = 1; dn = 0;
        repeat (2) begin model_advance; tick; end
        n_total++; if ({msd, lsd} !== 7'h37) $display("FAIL pre_reset_value: got %h expected 37", {msd, lsd}); else n_pass++;
        ld = 1; lmsd = 6; llsd = 1;
        model_advance;
        tick;
        ld = 0;
        n_total++; if (lerr !== 1'b1) $display("FAIL pre_reset_err: got %b expected 1", lerr); else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_total++; if ({msd, lsd} !== 7'h00) $display("FAIL async_reset_value: got %h expected 00", {msd, lsd}); else n_pass++;
        n_total++; if (lerr !== 1'b0) $display("FAIL async_reset_err: got %b expected 0", lerr); else n_pass++;
        n_total++; if ({msd2, lsd2} !== 6'h01) $display("FAIL async_reset_12h: got %h expected 01", {msd2, lsd2}); else n_pass++;
        tick;
        rst_n = 1'b1;
        mv = 0; mv2 = 1; mle = 0; mle2 = 0;
        model_advance;
        tick;
        n_total++; if ({msd, lsd} !== 7'h01) $display("FAIL resume_value: got %h expected 01", {msd, lsd}); else n_pass++;
        en = 0; ld = 1; lmsd = 5; llsd = 9;
        model_advance;
        tick;
        ld = 0;
        #1;
        n_total++; if (carry !== 1'b0) $display("FAIL idle_terminal_carry: got %b expected 0", carry); else n_pass++;
        model_advance;
        tick;
        n_total++; if ({msd, lsd} !== 7'h59) $display("FAIL idle_hold: got %h expected 59", {msd, lsd}); else n_pass++;
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            dn    = 1'($urandom_range(0, 1));
            ld    = ($urandom_range(0, 9) == 0);
            lmsd  = 3'($urandom_range(0, 7));
            llsd  = 4'($urandom_range(0, 15));
            en2   = ($urandom_range(0, 3) != 0);
            dn2   = 1'($urandom_range(0, 1));
            ld2   = ($urandom_range(0, 9) == 0);
            lmsd2 = 2'($urandom_range(0, 3));
            llsd2 = 4'($urandom_range(0, 15));
            #1;
            n_total++; if (carry !== exp_carry(mv, en, dn, ld, 0, 59)) $display("FAIL rnd_carry: at %0d got %b expected %b", mv, carry, exp_carry(mv, en, dn, ld, 0, 59)); else n_pass++;
            n_total++; if (carry2 !== exp_carry(mv2, en2, dn2, ld2, 1, 12)) $display("FAIL rnd_carry_12h: at %0d got %b expected %b", mv2, carry2, exp_carry(mv2, en2, dn2, ld2, 1, 12)); else n_pass++;
            model_advance;
            tick;
            n_total++; if ({msd, lsd} !== dig(mv)) $display("FAIL rnd_value: got %h expected %h", {msd, lsd}, dig(mv)); else n_pass++;
            n_total++; if (lerr !== mle) $display("FAIL rnd_load_err: got %b expected %b", lerr, mle); else n_pass++;
            n_total++; if ({msd2, lsd2} !== dig2(mv2)) $display("FAIL rnd_value_12h: got %h expected %h", {msd2, lsd2}, dig2(mv2)); else n_pass++;
            n_total++; if (lerr2 !== mle2) $display("FAIL rnd_load_err_12h: got %b expected %b", lerr2, mle2); else n_pass++;
        end
        en = 0; ld = 0; en2 = 0; ld2 = 0;
    endtask

    initial begin
        test_reset;
        test_count_up;
        test_count_down;
        test_12h;
        test_load;
        test_load_priority;
        test_async_reset;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
